mem_wb_dual: RTL and testbench
==============================

// Module: mem_wb_dual
// PURPOSE
//  Back end of the dual-issue pipe: consumes the two EX/MEM lanes and owns the data memory and MEM/WB registers.
//  Produces every *_WB signal and the ForwardA/B codes that the front end takes as inputs.
//  Serialises bundles in which both lanes access memory, stalling the front end for one cycle.
// PARAMETERS
//  DATA_W   32    datapath width
//  ADDR_W   10    data-memory word-address width (address = aluResN_MEM[ADDR_W-1:0])
//  DEPTH    1024  data-memory words
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  rst              in   1   reset, asynchronous, active-high
//  MemReadEnN_MEM, MemWriteEnN_MEM, MemtoRegN_MEM, RegWriteEnN_MEM, jalN_MEM   in  1  lane N (N=1,2) control
//  DestRegN_MEM, rtN_MEM      in   5       lane N destination / store-source register
//  return_addrN_MEM           in   10      lane N link address (already PC+1)
//  aluResN_MEM, forwardBResN_MEM  in  32   lane N ALU result / store data
//  rsN_EX, rtN_EX             in   5       EX-stage source registers, lane N
//  regWriteN_WB, jalN_WB      out  1       lane N write enable / jal flag to register file
//  writeRegN_WB               out  5       lane N destination
//  writeDataN_WB, aluResN_WB  out  32      lane N final result (both carry identical value)
//  ForwardA_N, ForwardB_N     out  3       forwarding selects for EX lane N
//  mem_stall                  out  1       hold IF/ID, ID/EX, EX/MEM this cycle
// BEHAVIOUR
//  Reset: all MEM/WB regs 0 (regWrite*_WB=0, writeData*_WB=0), FSM=IDLE, mem_stall=0, hold reg 0, RAM contents untouched.
//  Memory: single port, combinational read, write on clk edge; one access per cycle max.
//  memN = MemReadEnN_MEM | MemWriteEnN_MEM; dual = mem1 & mem2.
//  FSM IDLE:
//   - !dual: lane with memN (if any) accesses RAM; MEM/WB loads both lanes; mem_stall=0.
//   - dual: lane 1 accesses RAM; read data -> hold1; mem_stall=1; MEM/WB holds; go SECOND.
//  FSM SECOND: lane 2 accesses RAM (lane 1 NOT re-issued, its store already done);
//   MEM/WB loads lane1 (load data from hold1) and lane2; mem_stall=0; go IDLE.
//  Holding MEM/WB during stall re-writes the same reg/value: idempotent and keeps WB forwarding valid.
//  Result mux per lane: jal -> {22'b0, return_addr}; else MemtoReg -> RAM/hold data; else aluRes.
//  Store data: if regWriteM_WB && writeRegM_WB==rtN_MEM && !=0, use writeDataM_WB (lane2_WB priority) else forwardBRes.
//  Intra-bundle RAW (lane2 reads lane1 dest) is excluded by issue logic; not handled here.
//  Forward codes: 0 regfile, 1 aluRes1_MEM, 2 aluRes2_MEM, 3 aluRes1_WB, 4 aluRes2_WB; 5-7 unused.
//   - Priority: lane2_MEM > lane1_MEM > lane2_WB > lane1_WB.
//   - Requires RegWriteEn set, dest != 0, dest == rs (A) / rt (B).
//   - MEM-stage loads are never forwarded (load hazard stall upstream guarantees WB availability).
//  Reset asserted mid-SECOND: FSM->IDLE, stall drops immediately; pending lane2 access is discarded.
// STRUCTURE
//  Shared package pipe_pkg: FWD_RF/FWD_M1/FWD_M2/FWD_W1/FWD_W2 constants, mem FSM state enum.
//  One sub-module: dual_dmem (DEPTH x DATA_W, 1 port, async read, sync write).
//  Forwarding unit, result muxes, FSM and MEM/WB regs live in mem_wb_dual.
// TESTING
//  1. Lane1 sw 0x1234 @5, lane2 lw @5, same bundle -> mem_stall=1 one cycle; lane2 writeData2_WB=0x1234.
//  2. Lane1 lw $8 @7 (mem[7]=0xA5), lane2 add -> no stall; next cycle regWrite1_WB=1, writeReg1_WB=8, writeData1_WB=0xA5.
//  3. Lane2_MEM and lane1_MEM both write $3, EX rs1=3 -> ForwardA_1=2; only WB writes $3 -> code 3 or 4.
//  4. jal in lane1, return_addr1_MEM=0x040 -> writeData1_WB=0x00000040, jal1_WB=1.
//  5. WB lw $9=0xBEEF, MEM sw rt=9 @12 -> mem[12]=0xBEEF; dest $0 in MEM never forwarded (code 0).
//  6. rst asserted during SECOND -> regWrite*_WB=0, mem_stall=0 same cycle; lane2 store not performed.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the dual-issue back end: forwarding select codes,
// the memory-serialisation FSM states and a forwarding-hit helper.
package pipe_pkg;

  localparam logic [2:0] FWD_RF = 3'd0;
  localparam logic [2:0] FWD_M1 = 3'd1;
  localparam logic [2:0] FWD_M2 = 3'd2;
  localparam logic [2:0] FWD_W1 = 3'd3;
  localparam logic [2:0] FWD_W2 = 3'd4;

  typedef enum logic {
    MEM_IDLE,
    MEM_SECOND
  } mem_state_t;

  // A producer matches a consumer when it writes a real register equal to the source.
  function automatic logic fwd_hit(input logic we, input logic [4:0] dest, input logic [4:0] src);
    return we && (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/dual_dmem.sv
// Single-port data memory: combinational read, write on the rising clock edge.
// Contents are never reset.
module dual_dmem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_dual.sv
// Back end of the dual-issue pipe: data memory access for both lanes, MEM/WB
// registers, result muxes and the EX forwarding unit. Bundles where both lanes
// touch memory are serialised over two cycles with a one-cycle front-end stall.
module mem_wb_dual
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadEn1_MEM, MemWriteEn1_MEM, MemtoReg1_MEM, RegWriteEn1_MEM, jal1_MEM,
  input  logic              MemReadEn2_MEM, MemWriteEn2_MEM, MemtoReg2_MEM, RegWriteEn2_MEM, jal2_MEM,
  input  logic [4:0]        DestReg1_MEM, rt1_MEM, DestReg2_MEM, rt2_MEM,
  input  logic [9:0]        return_addr1_MEM, return_addr2_MEM,
  input  logic [DATA_W-1:0] aluRes1_MEM, forwardBRes1_MEM, aluRes2_MEM, forwardBRes2_MEM,
  input  logic [4:0]        rs1_EX, rt1_EX, rs2_EX, rt2_EX,
  output logic              regWrite1_WB, jal1_WB, regWrite2_WB, jal2_WB,
  output logic [4:0]        writeReg1_WB, writeReg2_WB,
  output logic [DATA_W-1:0] writeData1_WB, aluRes1_WB, writeData2_WB, aluRes2_WB,
  output logic [2:0]        ForwardA_1, ForwardB_1, ForwardA_2, ForwardB_2,
  output logic              mem_stall
);

  mem_state_t        state, state_nxt;
  logic              mem1, mem2, dual;
  logic              stall, ld_wb, ld_hold, sel2, acc;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, hold1;
  logic [DATA_W-1:0] st1, st2, res1, res2;

  assign mem1 = MemReadEn1_MEM | MemWriteEn1_MEM;
  assign mem2 = MemReadEn2_MEM | MemWriteEn2_MEM;
  assign dual = mem1 & mem2;

  // Memory FSM next state, port arbitration and MEM/WB load control
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ld_wb     = 1'b1;
    ld_hold   = 1'b0;
    sel2      = 1'b0;
    acc       = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (dual) begin
          stall     = 1'b1;
          ld_wb     = 1'b0;
          ld_hold   = 1'b1;
          acc       = 1'b1;
          state_nxt = MEM_SECOND;
        end else begin
          acc  = mem1 | mem2;
          sel2 = ~mem1;
        end
      end
      MEM_SECOND: begin
        sel2      = 1'b1;
        acc       = 1'b1;
        state_nxt = MEM_IDLE;
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  assign mem_stall = stall & ~rst;

  // Store data bypass from the WB stage, lane 2 being the younger producer
  always_comb begin
    st1 = forwardBRes1_MEM;
    if (fwd_hit(regWrite2_WB, writeReg2_WB, rt1_MEM))      st1 = writeData2_WB;
    else if (fwd_hit(regWrite1_WB, writeReg1_WB, rt1_MEM)) st1 = writeData1_WB;
    st2 = forwardBRes2_MEM;
    if (fwd_hit(regWrite2_WB, writeReg2_WB, rt2_MEM))      st2 = writeData2_WB;
    else if (fwd_hit(regWrite1_WB, writeReg1_WB, rt2_MEM)) st2 = writeData1_WB;
  end

  assign ram_addr  = sel2 ? aluRes2_MEM[ADDR_W-1:0] : aluRes1_MEM[ADDR_W-1:0];
  assign ram_wdata = sel2 ? st2 : st1;
  assign ram_we    = acc & ~rst & (sel2 ? MemWriteEn2_MEM : MemWriteEn1_MEM);

  dual_dmem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dmem (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Per-lane result select; lane 1 load data comes from the hold reg on the second cycle
  always_comb begin
    if (jal1_MEM)           res1 = {{(DATA_W-10){1'b0}}, return_addr1_MEM};
    else if (MemtoReg1_MEM) res1 = (state == MEM_SECOND) ? hold1 : ram_rdata;
    else                    res1 = aluRes1_MEM;
    if (jal2_MEM)           res2 = {{(DATA_W-10){1'b0}}, return_addr2_MEM};
    else if (MemtoReg2_MEM) res2 = ram_rdata;
    else                    res2 = aluRes2_MEM;
  end

  // Forwarding selects: lane2_MEM > lane1_MEM > lane2_WB > lane1_WB, MEM loads excluded
  always_comb begin
    ForwardA_1 = FWD_RF;
    ForwardB_1 = FWD_RF;
    ForwardA_2 = FWD_RF;
    ForwardB_2 = FWD_RF;
    if (fwd_hit(RegWriteEn2_MEM & ~MemReadEn2_MEM, DestReg2_MEM, rs1_EX))      ForwardA_1 = FWD_M2;
    else if (fwd_hit(RegWriteEn1_MEM & ~MemReadEn1_MEM, DestReg1_MEM, rs1_EX)) ForwardA_1 = FWD_M1;
    else if (fwd_hit(regWrite2_WB, writeReg2_WB, rs1_EX))                      ForwardA_1 = FWD_W2;
    else if (fwd_hit(regWrite1_WB, writeReg1_WB, rs1_EX))                      ForwardA_1 = FWD_W1;
    if (fwd_hit(RegWriteEn2_MEM & ~MemReadEn2_MEM, DestReg2_MEM, rt1_EX))      ForwardB_1 = FWD_M2;
    else if (fwd_hit(RegWriteEn1_MEM & ~MemReadEn1_MEM, DestReg1_MEM, rt1_EX)) ForwardB_1 = FWD_M1;
    else if (fwd_hit(regWrite2_WB, writeReg2_WB, rt1_EX))                      ForwardB_1 = FWD_W2;
    else if (fwd_hit(regWrite1_WB, writeReg1_WB, rt1_EX))                      ForwardB_1 = FWD_W1;
    if (fwd_hit(RegWriteEn2_MEM & ~MemReadEn2_MEM, DestReg2_MEM, rs2_EX))      ForwardA_2 = FWD_M2;
    else if (fwd_hit(RegWriteEn1_MEM & ~MemReadEn1_MEM, DestReg1_MEM, rs2_EX)) ForwardA_2 = FWD_M1;
    else if (fwd_hit(regWrite2_WB, writeReg2_WB, rs2_EX))                      ForwardA_2 = FWD_W2;
    else if (fwd_hit(regWrite1_WB, writeReg1_WB, rs2_EX))                      ForwardA_2 = FWD_W1;
    if (fwd_hit(RegWriteEn2_MEM & ~MemReadEn2_MEM, DestReg2_MEM, rt2_EX))      ForwardB_2 = FWD_M2;
    else if (fwd_hit(RegWriteEn1_MEM & ~MemReadEn1_MEM, DestReg1_MEM, rt2_EX)) ForwardB_2 = FWD_M1;
    else if (fwd_hit(regWrite2_WB, writeReg2_WB, rt2_EX))                      ForwardB_2 = FWD_W2;
    else if (fwd_hit(regWrite1_WB, writeReg1_WB, rt2_EX))                      ForwardB_2 = FWD_W1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  // Lane 1 load data captured on the first cycle of a serialised bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hold1 <= '0;
    else if (ld_hold) hold1 <= ram_rdata;
  end

  // MEM/WB registers, held while the bundle is being serialised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWrite1_WB  <= 1'b0;
      jal1_WB       <= 1'b0;
      writeReg1_WB  <= '0;
      writeData1_WB <= '0;
      regWrite2_WB  <= 1'b0;
      jal2_WB       <= 1'b0;
      writeReg2_WB  <= '0;
      writeData2_WB <= '0;
    end else if (ld_wb) begin
      regWrite1_WB  <= RegWriteEn1_MEM;
      jal1_WB       <= jal1_MEM;
      writeReg1_WB  <= DestReg1_MEM;
      writeData1_WB <= res1;
      regWrite2_WB  <= RegWriteEn2_MEM;
      jal2_WB       <= jal2_MEM;
      writeReg2_WB  <= DestReg2_MEM;
      writeData2_WB <= res2;
    end
  end

  assign aluRes1_WB = writeData1_WB;
  assign aluRes2_WB = writeData2_WB;

endmodule

// File: tb/tb_mem_wb_dual.sv
// Directed testbench for mem_wb_dual: inputs change on the falling edge,
// combinational outputs are sampled 1ns later, registered outputs 1ns after
// the rising edge.
module tb_mem_wb_dual;

  logic        clk, rst;
  logic        MemReadEn1_MEM, MemWriteEn1_MEM, MemtoReg1_MEM, RegWriteEn1_MEM, jal1_MEM;
  logic        MemReadEn2_MEM, MemWriteEn2_MEM, MemtoReg2_MEM, RegWriteEn2_MEM, jal2_MEM;
  logic [4:0]  DestReg1_MEM, rt1_MEM, DestReg2_MEM, rt2_MEM;
  logic [9:0]  return_addr1_MEM, return_addr2_MEM;
  logic [31:0] aluRes1_MEM, forwardBRes1_MEM, aluRes2_MEM, forwardBRes2_MEM;
  logic [4:0]  rs1_EX, rt1_EX, rs2_EX, rt2_EX;
  logic        regWrite1_WB, jal1_WB, regWrite2_WB, jal2_WB;
  logic [4:0]  writeReg1_WB, writeReg2_WB;
  logic [31:0] writeData1_WB, aluRes1_WB, writeData2_WB, aluRes2_WB;
  logic [2:0]  ForwardA_1, ForwardB_1, ForwardA_2, ForwardB_2;
  logic        mem_stall;

  int nvec = 0;
  int nerr = 0;

  mem_wb_dual #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .MemReadEn1_MEM(MemReadEn1_MEM), .MemWriteEn1_MEM(MemWriteEn1_MEM), .MemtoReg1_MEM(MemtoReg1_MEM),
    .RegWriteEn1_MEM(RegWriteEn1_MEM), .jal1_MEM(jal1_MEM),
    .MemReadEn2_MEM(MemReadEn2_MEM), .MemWriteEn2_MEM(MemWriteEn2_MEM), .MemtoReg2_MEM(MemtoReg2_MEM),
    .RegWriteEn2_MEM(RegWriteEn2_MEM), .jal2_MEM(jal2_MEM),
    .DestReg1_MEM(DestReg1_MEM), .rt1_MEM(rt1_MEM), .DestReg2_MEM(DestReg2_MEM), .rt2_MEM(rt2_MEM),
    .return_addr1_MEM(return_addr1_MEM), .return_addr2_MEM(return_addr2_MEM),
    .aluRes1_MEM(aluRes1_MEM), .forwardBRes1_MEM(forwardBRes1_MEM),
    .aluRes2_MEM(aluRes2_MEM), .forwardBRes2_MEM(forwardBRes2_MEM),
    .rs1_EX(rs1_EX), .rt1_EX(rt1_EX), .rs2_EX(rs2_EX), .rt2_EX(rt2_EX),
    .regWrite1_WB(regWrite1_WB), .jal1_WB(jal1_WB), .regWrite2_WB(regWrite2_WB), .jal2_WB(jal2_WB),
    .writeReg1_WB(writeReg1_WB), .writeReg2_WB(writeReg2_WB),
    .writeData1_WB(writeData1_WB), .aluRes1_WB(aluRes1_WB),
    .writeData2_WB(writeData2_WB), .aluRes2_WB(aluRes2_WB),
    .ForwardA_1(ForwardA_1), .ForwardB_1(ForwardB_1), .ForwardA_2(ForwardA_2), .ForwardB_2(ForwardB_2),
    .mem_stall(mem_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {MemReadEn1_MEM, MemWriteEn1_MEM, MemtoReg1_MEM, RegWriteEn1_MEM, jal1_MEM} = '0;
    {MemReadEn2_MEM, MemWriteEn2_MEM, MemtoReg2_MEM, RegWriteEn2_MEM, jal2_MEM} = '0;
    {DestReg1_MEM, rt1_MEM, DestReg2_MEM, rt2_MEM} = '0;
    return_addr1_MEM = '0; return_addr2_MEM = '0;
    aluRes1_MEM = '0; forwardBRes1_MEM = '0; aluRes2_MEM = '0; forwardBRes2_MEM = '0;
    {rs1_EX, rt1_EX, rs2_EX, rt2_EX} = '0;
  endtask

  task automatic fall();
    @(negedge clk);
    clr();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  // Lane 1 store: mem[a] <= d
  task automatic sw1(input logic [31:0] a, input logic [31:0] d);
    MemWriteEn1_MEM = 1'b1; aluRes1_MEM = a; forwardBRes1_MEM = d;
  endtask

  task automatic lw1(input logic [4:0] r, input logic [31:0] a);
    MemReadEn1_MEM = 1'b1; MemtoReg1_MEM = 1'b1; RegWriteEn1_MEM = 1'b1; DestReg1_MEM = r; aluRes1_MEM = a;
  endtask

  task automatic lw2(input logic [4:0] r, input logic [31:0] a);
    MemReadEn2_MEM = 1'b1; MemtoReg2_MEM = 1'b1; RegWriteEn2_MEM = 1'b1; DestReg2_MEM = r; aluRes2_MEM = a;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    rise();
    check("rst_regWrite1", regWrite1_WB, 0);
    check("rst_writeData1", writeData1_WB, 0);
    check("rst_regWrite2", regWrite2_WB, 0);
    check("rst_stall", mem_stall, 0);
    check("rst_fwdA1", ForwardA_1, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: lane1 sw 0x1234 @5, lane2 lw $6 @5 in one bundle
    fall();
    sw1(5, 32'h1234); rt1_MEM = 5'd4;
    lw2(6, 5);
    #1 check("t1_stall_first", mem_stall, 1);
    rise();
    check("t1_stall_second", mem_stall, 0);
    check("t1_wb_held", regWrite2_WB, 0);
    rise();
    check("t1_regWrite2", regWrite2_WB, 1);
    check("t1_writeReg2", writeReg2_WB, 6);
    check("t1_writeData2", writeData2_WB, 32'h1234);
    check("t1_aluRes2", aluRes2_WB, 32'h1234);
    check("t1_regWrite1", regWrite1_WB, 0);

    // 2: preload mem[7]=0xA5, then lane1 lw $8 @7 with lane2 add $10
    fall();
    sw1(7, 32'hA5);
    fall();
    lw1(8, 7);
    RegWriteEn2_MEM = 1'b1; DestReg2_MEM = 5'd10; aluRes2_MEM = 32'h55;
    #1 check("t2_no_stall", mem_stall, 0);
    rise();
    check("t2_regWrite1", regWrite1_WB, 1);
    check("t2_writeReg1", writeReg1_WB, 8);
    check("t2_writeData1", writeData1_WB, 32'hA5);
    check("t2_writeData2", writeData2_WB, 32'h55);

    // 3: forwarding priority; WB now holds $8 (lane1) and $10 (lane2)
    fall();
    RegWriteEn1_MEM = 1'b1; DestReg1_MEM = 5'd3; aluRes1_MEM = 32'h33;
    RegWriteEn2_MEM = 1'b1; DestReg2_MEM = 5'd3; aluRes2_MEM = 32'h44;
    rs1_EX = 5'd3; rt1_EX = 5'd8; rs2_EX = 5'd10; rt2_EX = 5'd3;
    #1;
    check("t3_fwdA1_m2", ForwardA_1, 2);
    check("t3_fwdB1_w1", ForwardB_1, 3);
    check("t3_fwdA2_w2", ForwardA_2, 4);
    check("t3_fwdB2_m2", ForwardB_2, 2);
    fall();
    RegWriteEn1_MEM = 1'b1; DestReg1_MEM = 5'd3; aluRes1_MEM = 32'h33;
    lw2(3, 7);
    rs1_EX = 5'd3;
    #1 check("t3_load_not_fwd", ForwardA_1, 1);
    fall();
    RegWriteEn1_MEM = 1'b1; DestReg1_MEM = 5'd3; aluRes1_MEM = 32'h33;
    RegWriteEn2_MEM = 1'b1; DestReg2_MEM = 5'd11; aluRes2_MEM = 32'h44;
    rise();
    fall();
    rs1_EX = 5'd3; rs2_EX = 5'd11;
    #1;
    check("t3_fwdA1_wb1", ForwardA_1, 3);
    check("t3_fwdA2_wb2", ForwardA_2, 4);

    // 4: jal in lane 1
    fall();
    jal1_MEM = 1'b1; RegWriteEn1_MEM = 1'b1; DestReg1_MEM = 5'd31;
    return_addr1_MEM = 10'h040; aluRes1_MEM = 32'hDEAD;
    rise();
    check("t4_writeData1", writeData1_WB, 32'h40);
    check("t4_jal1", jal1_WB, 1);
    check("t4_writeReg1", writeReg1_WB, 31);

    // 5: lane2 stores 0xBEEF @20, lane1 lw $9 @20, then sw rt=9 @12 uses WB value
    fall();
    MemWriteEn2_MEM = 1'b1; aluRes2_MEM = 32'd20; forwardBRes2_MEM = 32'hBEEF;
    fall();
    lw1(9, 20);
    rise();
    check("t5_lw9", writeData1_WB, 32'hBEEF);
    fall();
    MemWriteEn2_MEM = 1'b1; rt2_MEM = 5'd9; aluRes2_MEM = 32'd12; forwardBRes2_MEM = 32'h0;
    RegWriteEn1_MEM = 1'b1; DestReg1_MEM = 5'd0; aluRes1_MEM = 32'h77;
    rs1_EX = 5'd0; rs2_EX = 5'd0;
    #1;
    check("t5_dest0_fwdA1", ForwardA_1, 0);
    check("t5_dest0_fwdA2", ForwardA_2, 0);
    fall();
    lw1(5, 12);
    rise();
    check("t5_mem12", writeData1_WB, 32'hBEEF);

    // Dual load: lane1 result comes through the hold register
    fall();
    lw1(12, 5);
    lw2(13, 7);
    rise();
    rise();
    check("hold_lane1", writeData1_WB, 32'h1234);
    check("hold_lane2", writeData2_WB, 32'hA5);

    // 6: reset mid-SECOND discards the lane2 store
    fall();
    MemWriteEn2_MEM = 1'b1; aluRes2_MEM = 32'd31; forwardBRes2_MEM = 32'h5A5A;
    RegWriteEn1_MEM = 1'b1; DestReg1_MEM = 5'd7; aluRes1_MEM = 32'h1;
    rise();
    check("t6_pre_regWrite1", regWrite1_WB, 1);
    fall();
    sw1(30, 32'h1111);
    MemWriteEn2_MEM = 1'b1; aluRes2_MEM = 32'd31; forwardBRes2_MEM = 32'h2222;
    rise();
    #1 rst = 1'b1;
    #1;
    check("t6_rst_regWrite1", regWrite1_WB, 0);
    check("t6_rst_writeData1", writeData1_WB, 0);
    check("t6_rst_stall", mem_stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t6_fsm_idle", mem_stall, 1);
    #1 clr();
    lw1(1, 31);
    #1 check("t6_lw_no_stall", mem_stall, 0);
    rise();
    check("t6_mem31_kept", writeData1_WB, 32'h5A5A);
    fall();
    lw1(2, 30);
    rise();
    check("t6_mem30_written", writeData1_WB, 32'h1111);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
